// File: rtl/fp_norm_pack_seq_if.sv
// Handshake/bus bundle for the FP normalise/round/pack stage.
// Ports (slave = the stage): in_valid/in_ready + in_sign/in_exp/in_man/in_guard/in_sticky operand,
//   out_valid/out_ready + out_sign/out_exp/out_man packed result with overflow/underflow/zero flags.
interface fp_norm_pack_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W+1:0] in_man;     // [MAN_W+1] carry, [MAN_W] hidden, [MAN_W-1:0] fraction
  logic             in_guard;
  logic             in_sticky;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [EXP_W-1:0] out_exp;
  logic [MAN_W-1:0] out_man;
  logic             overflow;
  logic             underflow;
  logic             zero;

  // Producer of operands / consumer of results
  modport master (
    output in_valid, in_sign, in_exp, in_man, in_guard, in_sticky, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_man, overflow, underflow, zero
  );

  // The normalise/pack stage itself
  modport slave (
    input  in_valid, in_sign, in_exp, in_man, in_guard, in_sticky, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_man, overflow, underflow, zero
  );
endinterface

// File: rtl/fp_norm_pack_seq.sv
// Purpose: normalise (right on carry, left one bit/cycle on cancellation), optionally round, and pack
//   an IEEE-style result with overflow/underflow/zero flags; tail of the FP adder datapath.
// Latency accept->out_valid: 1 (zero, overflow on carry), 2 (normalised, carry, denormal), 2+k (k left shifts).
// Backpressure: one op in flight; in_ready low from accept until the result handshake; DONE holds outputs.
// Ports: clk (rising edge), rst (synchronous, active high), bus (fp_norm_pack_seq_if.slave).
// Build option FP_ROUND_NEAREST_EN: round to nearest even in ROUND; when undefined ROUND truncates and
//   in_guard/in_sticky are ignored.
module fp_norm_pack_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic              clk,
  input  logic              rst,
  fp_norm_pack_seq_if.slave bus
);

  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_TWO = EXP_W'(2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;

  // Working copy of the operation. The carry bit is folded away at accept, so the
  // working mantissa only needs hidden + fraction.
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [MAN_W:0]   man_q, man_d;
  logic             uf_q, uf_d;

  // Registered outputs
  logic             out_valid_q, out_valid_d;
  logic             out_sign_q, out_sign_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic [MAN_W-1:0] out_man_q, out_man_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             zero_q, zero_d;

  // Exponent after the carry right shift; one extra bit so wrap past all-ones is visible
  logic [EXP_W:0]   in_exp_inc;
  // Bit entering the mantissa LSB on each left shift
  logic             shift_in;

  assign in_exp_inc = {1'b0, bus.in_exp} + 1'b1;

`ifdef FP_ROUND_NEAREST_EN
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             round_up;
  logic [MAN_W+1:0] man_rnd;
  logic [EXP_W:0]   rnd_exp_inc;

  assign shift_in    = guard_q;
  // Nearest-even: a tie (guard set, nothing below) rounds up only when the LSB is odd
  assign round_up    = guard_q & (sticky_q | man_q[0]);
  assign man_rnd     = {1'b0, man_q} + {{(MAN_W+1){1'b0}}, round_up};
  assign rnd_exp_inc = {1'b0, exp_q} + 1'b1;
`else
  // Truncation never looks below the fraction LSB, and the hidden bit is not packed.
  logic             unused_trunc;

  assign shift_in     = 1'b0;
  assign unused_trunc = ^{bus.in_guard, bus.in_sticky, man_q[MAN_W]};
`endif

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_sign_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_man   = out_man_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.zero      = zero_q;

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    man_d       = man_q;
    uf_d        = uf_q;
`ifdef FP_ROUND_NEAREST_EN
    guard_d     = guard_q;
    sticky_d    = sticky_q;
`endif
    out_valid_d = out_valid_q;
    out_sign_d  = out_sign_q;
    out_exp_d   = out_exp_q;
    out_man_d   = out_man_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        // rst forces the flops back to IDLE, so accepting here without looking at rst is safe
        if (bus.in_valid) begin
          sign_d = bus.in_sign;
          exp_d  = bus.in_exp;
          man_d  = bus.in_man[MAN_W:0];
          uf_d   = 1'b0;
`ifdef FP_ROUND_NEAREST_EN
          guard_d  = bus.in_guard;
          sticky_d = bus.in_sticky;
`endif
          if (bus.in_man == '0) begin
            out_valid_d = 1'b1;
            out_sign_d  = bus.in_sign;
            out_exp_d   = '0;
            out_man_d   = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            zero_d      = 1'b1;
            state_d     = DONE;
          end else if (bus.in_man[MAN_W+1]) begin
            man_d = bus.in_man[MAN_W+1:1];
`ifdef FP_ROUND_NEAREST_EN
            guard_d  = bus.in_man[0];
            sticky_d = bus.in_guard | bus.in_sticky;
`endif
            if (in_exp_inc >= {1'b0, EXP_MAX}) begin
              // Carry pushed the exponent to (or past) all-ones: saturate straight away
              out_valid_d = 1'b1;
              out_sign_d  = bus.in_sign;
              out_exp_d   = EXP_MAX;
              out_man_d   = '0;
              overflow_d  = 1'b1;
              underflow_d = 1'b0;
              zero_d      = 1'b0;
              state_d     = DONE;
            end else begin
              exp_d   = in_exp_inc[EXP_W-1:0];
              state_d = ROUND;
            end
          end else if (bus.in_man[MAN_W]) begin
            state_d = ROUND;
          end else if (bus.in_exp == '0) begin
            uf_d    = 1'b1;
            state_d = ROUND;
          end else begin
            state_d = NORM;
          end
        end
      end

      NORM: begin
        if (exp_q == EXP_ONE) begin
          // exp 1 with no hidden bit is already the denormal scale: re-encode as exp 0
          exp_d   = '0;
          uf_d    = 1'b1;
          state_d = ROUND;
        end else begin
          man_d = {man_q[MAN_W-1:0], shift_in};
`ifdef FP_ROUND_NEAREST_EN
          guard_d = 1'b0;
`endif
          exp_d = exp_q - 1'b1;
          // Look at the bit about to become hidden so the exit costs no extra cycle
          if (man_q[MAN_W-1]) begin
            state_d = ROUND;
          end else if (exp_q == EXP_TWO) begin
            // This shift lands on exp 1 still unnormalised: stop here as a denormal
            exp_d   = '0;
            uf_d    = 1'b1;
            state_d = ROUND;
          end
        end
      end

      ROUND: begin
        out_valid_d = 1'b1;
        out_sign_d  = sign_q;
        zero_d      = 1'b0;
        overflow_d  = 1'b0;
        state_d     = DONE;
`ifdef FP_ROUND_NEAREST_EN
        if (man_rnd[MAN_W+1]) begin
          // Fraction rolled over: mantissa becomes 1.0 one binade up
          out_man_d   = '0;
          underflow_d = 1'b0;
          if (rnd_exp_inc >= {1'b0, EXP_MAX}) begin
            out_exp_d  = EXP_MAX;
            overflow_d = 1'b1;
          end else begin
            out_exp_d = rnd_exp_inc[EXP_W-1:0];
          end
        end else if (uf_q && man_rnd[MAN_W]) begin
          // Denormal rounded up into the hidden bit: smallest normal
          out_exp_d   = EXP_ONE;
          out_man_d   = man_rnd[MAN_W-1:0];
          underflow_d = 1'b0;
        end else begin
          out_exp_d   = exp_q;
          out_man_d   = man_rnd[MAN_W-1:0];
          underflow_d = uf_q;
        end
`else
        out_exp_d   = exp_q;
        out_man_d   = man_q[MAN_W-1:0];
        underflow_d = uf_q;
`endif
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          zero_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      man_q       <= '0;
      uf_q        <= 1'b0;
`ifdef FP_ROUND_NEAREST_EN
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_man_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      man_q       <= man_d;
      uf_q        <= uf_d;
`ifdef FP_ROUND_NEAREST_EN
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
`endif
      out_valid_q <= out_valid_d;
      out_sign_q  <= out_sign_d;
      out_exp_q   <= out_exp_d;
      out_man_q   <= out_man_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      zero_q      <= zero_d;
    end
  end

endmodule

// File: tb/tb_fp_norm_pack_seq.sv
// Self-checking bench for fp_norm_pack_seq (EXP_W=8, MAN_W=23): directed vector table,
// reset-during-NORM sequence, then randomized operations against a value-level reference model.
module tb_fp_norm_pack_seq;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef struct {
    logic        sign;
    logic [7:0]  e;
    logic [22:0] m;
    logic        ov;
    logic        uf;
    logic        z;
    int          lat;
  } res_t;

  typedef struct {
    string       name;
    logic        sg;
    logic [7:0]  e;
    logic [24:0] m;
    logic        g;
    logic        s;
    int          bp;
    res_t        x;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fp_norm_pack_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_norm_pack_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic res_t mkres(input logic sg, input logic [7:0] e, input logic [22:0] m,
                                 input logic ov, input logic uf, input logic z, input int lat);
    res_t r;
    r.sign = sg; r.e = e; r.m = m; r.ov = ov; r.uf = uf; r.z = z; r.lat = lat;
    return r;
  endfunction

  function automatic vec_t mkv(input string n, input logic sg, input logic [7:0] e, input logic [24:0] m,
                               input logic g, input logic s, input int bp, input res_t x);
    vec_t v;
    v.name = n; v.sg = sg; v.e = e; v.m = m; v.g = g; v.s = s; v.bp = bp; v.x = x;
    return v;
  endfunction

  // Value-level model: mantissa as an integer with hidden bit at 2^23, exponent as an int.
  function automatic res_t model(input logic sg, input int e_in, input longint m_in,
                                 input logic g_in, input logic s_in);
    res_t   r;
    int     e;
    longint m;
    logic   g;
    logic   s;
    logic   uf;
    int     k;
    int     n;
    r = mkres(sg, 8'h00, 23'h0, 1'b0, 1'b0, 1'b0, 0);
    e = e_in;
    m = m_in;
    uf = 1'b0;
`ifdef FP_ROUND_NEAREST_EN
    g = g_in;
    s = s_in;
`else
    g = 1'b0;
    s = 1'b0;
`endif
    if (m == 0) begin
      r.z = 1'b1;
      r.lat = 1;
      return r;
    end
    if (m >= 64'h100_0000) begin
      s = s | g;
      g = m[0];
      m = m >> 1;
      e = e + 1;
      if (e >= 255) begin
        r.e = 8'hFF; r.ov = 1'b1; r.lat = 1;
        return r;
      end
      r.lat = 2;
    end else if (m >= 64'h80_0000) begin
      r.lat = 2;
    end else if (e == 0) begin
      uf = 1'b1;
      r.lat = 2;
    end else begin
      k = 0;
      while ((m << k) < 64'h80_0000) k++;
      if (k <= e - 1) begin
        n = k;
        e = e - k;
      end else begin
        n = e - 1;
        e = 0;
        uf = 1'b1;
      end
      if (n > 0) begin
        m = (m << n) | (longint'(g) << (n - 1));
        g = 1'b0;
      end
      // The NORM state occupies at least one cycle even when it ends up shifting nothing
      r.lat = 2 + ((n > 0) ? n : 1);
    end
`ifdef FP_ROUND_NEAREST_EN
    if (g && (s || m[0])) begin
      m = m + 1;
      if (m >= 64'h100_0000) begin
        m = 64'h80_0000;
        e = e + 1;
        uf = 1'b0;
        if (e >= 255) begin
          r.e = 8'hFF; r.m = '0; r.ov = 1'b1; r.uf = 1'b0;
          return r;
        end
      end else if (uf && m >= 64'h80_0000) begin
        e = 1;
        uf = 1'b0;
      end
    end
`else
    if (s) r.lat = r.lat + 0;
`endif
    r.e = e[7:0];
    r.m = m[22:0];
    r.uf = uf;
    return r;
  endfunction

  // Starts and ends on a falling edge.
  task automatic run_op(input string tag, input logic sg, input logic [7:0] e, input logic [24:0] m,
                        input logic g, input logic s, input int bp, input res_t x);
    int lat;
    int waitc;
    waitc = 0;
    while (bus.in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
    bus.in_sign = sg; bus.in_exp = e; bus.in_man = m;
    bus.in_guard = g; bus.in_sticky = s; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(x.lat));
    chk({tag, " sign"}, 32'(bus.out_sign), 32'(x.sign));
    chk({tag, " exp"}, 32'(bus.out_exp), 32'(x.e));
    chk({tag, " man"}, 32'(bus.out_man), 32'(x.m));
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(x.ov));
    chk({tag, " underflow"}, 32'(bus.underflow), 32'(x.uf));
    chk({tag, " zero"}, 32'(bus.zero), 32'(x.z));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({tag, " held valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, " held exp"}, 32'(bus.out_exp), 32'(x.e));
      chk({tag, " held man"}, 32'(bus.out_man), 32'(x.m));
      chk({tag, " in_ready while held"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    chk({tag, " in_ready at handshake"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " valid cleared"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " flags cleared"}, 32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[7];
    res_t        x;
    logic        sg, g, s;
    logic [7:0]  e;
    logic [24:0] m;
    int unsigned shape, p, er, bp;
    int          seen;

    vecs[0] = mkv("carry_bp", 1'b0, 8'h80, 25'h180_0000, 1'b0, 1'b0, 3,
                  mkres(1'b0, 8'h81, 23'h40_0000, 1'b0, 1'b0, 1'b0, 2));
    vecs[1] = mkv("cancel", 1'b0, 8'h85, 25'h010_0000, 1'b0, 1'b0, 0,
                  mkres(1'b0, 8'h82, 23'h0, 1'b0, 1'b0, 1'b0, 5));
    vecs[2] = mkv("zero", 1'b1, 8'h40, 25'h0, 1'b0, 1'b0, 0,
                  mkres(1'b1, 8'h00, 23'h0, 1'b0, 1'b0, 1'b1, 1));
    vecs[3] = mkv("overflow", 1'b0, 8'hFE, 25'h100_0000, 1'b0, 1'b0, 0,
                  mkres(1'b0, 8'hFF, 23'h0, 1'b1, 1'b0, 1'b0, 1));
    vecs[4] = mkv("underflow", 1'b0, 8'h02, 25'h020_0000, 1'b0, 1'b0, 1,
                  mkres(1'b0, 8'h00, 23'h40_0000, 1'b0, 1'b1, 1'b0, 3));
`ifdef FP_ROUND_NEAREST_EN
    vecs[5] = mkv("round", 1'b0, 8'h80, 25'h0FF_FFFF, 1'b1, 1'b1, 0,
                  mkres(1'b0, 8'h81, 23'h0, 1'b0, 1'b0, 1'b0, 2));
`else
    vecs[5] = mkv("round", 1'b0, 8'h80, 25'h0FF_FFFF, 1'b1, 1'b1, 0,
                  mkres(1'b0, 8'h80, 23'h7F_FFFF, 1'b0, 1'b0, 1'b0, 2));
`endif
    vecs[6] = mkv("denormal", 1'b1, 8'h00, 25'h001_2345, 1'b0, 1'b0, 0,
                  mkres(1'b1, 8'h00, 23'h01_2345, 1'b0, 1'b1, 1'b0, 2));

    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_man = '0;
    bus.in_guard = 1'b0; bus.in_sticky = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset flags", 32'({bus.overflow, bus.underflow, bus.zero}), 32'd0);
    chk("reset result", 32'({bus.out_sign, bus.out_exp, bus.out_man}), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready after reset", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].name, vecs[i].sg, vecs[i].e, vecs[i].m, vecs[i].g, vecs[i].s, vecs[i].bp, vecs[i].x);
    end

    // Reset while the cancellation operation is shifting in NORM
    bus.in_sign = 1'b0; bus.in_exp = 8'h85; bus.in_man = 25'h010_0000;
    bus.in_guard = 1'b0; bus.in_sticky = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("norm_rst in_ready during rst", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("norm_rst out_valid during rst", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("norm_rst in_ready after rst", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("norm_rst abandoned op produced out_valid", 32'(seen), 32'd0);
    run_op("after_rst", vecs[1].sg, vecs[1].e, vecs[1].m, vecs[1].g, vecs[1].s, 0, vecs[1].x);

    // Randomized operations against the reference model
    for (int i = 0; i < 300; i++) begin
      shape = $urandom_range(0, 9);
      if (shape == 0) begin
        m = '0;
      end else if (shape <= 2) begin
        m = 25'h100_0000 | 25'($urandom & 32'hFF_FFFF);
      end else if (shape <= 4) begin
        m = 25'h080_0000 | 25'($urandom & 32'h7F_FFFF);
      end else begin
        p = $urandom_range(0, 22);
        m = 25'((32'd1 << p) | ($urandom & ((32'd1 << p) - 32'd1)));
      end
      er = $urandom_range(0, 3);
      if (er == 0) e = 8'($urandom_range(0, 4));
      else if (er == 1) e = 8'($urandom_range(250, 255));
      else e = 8'($urandom_range(0, 255));
      sg = 1'($urandom_range(0, 1));
      g  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      bp = $urandom_range(0, 2);
      x = model(sg, int'(e), longint'(m), g, s);
      run_op($sformatf("rnd%0d", i), sg, e, m, g, s, int'(bp), x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_norm_pack_seq.md
Name: fp_norm_pack_seq

Overview:
- Sequential normalise/round/pack stage at the tail of the floating-point adder datapath. Follows the mantissa add/subtract stage.
- Takes a sign, an exponent and a raw mantissa sum that may carry out or have leading zeros.
- Normalises the mantissa right (carry) or left (cancellation, one bit per cycle), optionally rounds, and packs an IEEE-style result with overflow, underflow and zero flags.
- Uses a valid/ready handshake on both sides; one operation in flight.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored fraction width (hidden bit excluded).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an operation
- in_sign  in  1  result sign
- in_exp  in  EXP_W  biased exponent before normalisation
- in_man  in  MAN_W+2  raw mantissa: bit MAN_W+1 = carry, bit MAN_W = hidden, [MAN_W-1:0] = fraction
- in_guard  in  1  first bit below fraction LSB
- in_sticky  in  1  OR of all bits below the guard bit
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sign  out  1  packed sign
- out_exp  out  EXP_W  packed exponent
- out_man  out  MAN_W  packed fraction
- overflow  out  1  result saturated to infinity
- underflow  out  1  result is denormal
- zero  out  1  result is exactly zero

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including out_valid and the flags.
  - in_ready is 0 while rst is high.
  - Reset mid-operation abandons the operation. No out_valid is produced for it.
- States: IDLE, NORM, ROUND, DONE.
- in_ready = (state==IDLE) && !rst.
- Accept occurs on in_valid && in_ready at cycle T. All inputs are latched. Exactly one of the following applies, checked in this order:
  - in_man==0: result = {in_sign, 0, 0}, zero=1, next state DONE (out_valid at T+1).
  - Carry bit set: mantissa >>1, exp+1.
    - The shifted-out bit becomes guard; old guard ORs into sticky.
    - If exp+1 == all-ones: result = infinity (exp all-ones, man 0), overflow=1, next state DONE.
    - Otherwise next state ROUND.
  - Hidden bit set: next state ROUND.
  - in_exp==0: denormal passthrough. underflow=1, next state ROUND.
  - Otherwise: next state NORM.
- NORM, each cycle:
  - Mantissa <<1 with guard shifted into the LSB; guard takes 0; sticky is held.
  - exp decrements by 1.
  - Leave for ROUND when the hidden bit becomes 1.
  - If exp==1 and the hidden bit is still 0 before a shift: stop shifting, set exp=0, underflow=1, go to ROUND.
  - At most MAN_W shift cycles.
- ROUND:
  - Applies the rounding rule (see Optional Feature).
  - Packs the fraction bits [MAN_W-1:0] into out_man.
  - Goes to DONE.
- DONE:
  - out_valid=1; all outputs are registered and held stable until out_ready.
  - On out_valid && out_ready: out_valid clears next cycle, state returns to IDLE, in_ready rises that same cycle.
  - No same-cycle accept/complete overlap.
- Latency (accept to out_valid):
  - Zero or overflow-on-carry: 1.
  - Already normalised or carry: 2.
  - k left shifts: 2+k.
- Flags are valid only with out_valid. They clear on the return to IDLE.

Optional Feature:
- Macro: FP_ROUND_NEAREST_EN.
- Defined: round to nearest even.
  - Increment the mantissa if guard && (sticky || fraction LSB).
  - If the increment carries into bit MAN_W+1: mantissa = 1.0 (fraction 0), exp+1.
  - If exp then equals all-ones: infinity, overflow=1.
  - A denormal that rounds up into the hidden bit becomes exp=1 with underflow cleared.
  - ROUND still takes exactly one cycle.
- Undefined: truncate. in_guard and in_sticky are ignored, and the ROUND state only packs.

Test Plan (EXP_W=8, MAN_W=23):
- Carry with backpressure: in_exp=0x80, in_man=0x1800000, guard=0, sticky=0; out_ready low for 3 cycles.
  - Required: out_valid at T+2, exp=0x81, man=0x400000.
  - Outputs stable while out_ready is low; in_ready=0 until the cycle after the handshake.
- Cancellation: in_exp=0x85, in_man=0x100000.
  - Required: 3 NORM cycles, out_valid at T+5, exp=0x82, man=0, flags 0.
- Zero: in_sign=1, in_man=0.
  - Required: out_valid at T+1, sign=1, exp=0, man=0, zero=1.
- Overflow: in_exp=0xFE, in_man=0x1000000.
  - Required: exp=0xFF, man=0, overflow=1.
- Underflow: in_exp=0x02, in_man=0x200000.
  - Required: exp=0, man=0x400000, underflow=1, out_valid at T+3.
- Rounding: in_exp=0x80, in_man=0xFFFFFF, guard=1, sticky=1.
  - With FP_ROUND_NEAREST_EN: exp=0x81, man=0.
  - Without it: exp=0x80, man=0x7FFFFF.
  - Repeat in NORM state with rst asserted: no out_valid; in_ready=1 on the first cycle after rst deasserts.
